// File: rtl/booth_mult_pkg.sv
// Shared constants for the Booth multiplier: state encoding, operand width, iteration count.
// Latency: none (declarations only).
// Backpressure: none. BOOTH_MULT_MULTU_EN widens the internal operand by one bit for unsigned support.
package mult_pkg;

  localparam int WIDTH = 32;

`ifdef BOOTH_MULT_MULTU_EN
  localparam int MULTU_EXT = 1;
`else
  localparam int MULTU_EXT = 0;
`endif

  // Internal operand width: one extra bit lets unsigned operands be zero-extended
  // and then treated as signed.
  localparam int N     = WIDTH + MULTU_EXT;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mult_step.sv
// One radix-2 Booth iteration: add/subtract M by {Q[0],q-1}, then arithmetic right shift of {P,Q,q-1}.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step
  import mult_pkg::*;
#(
  parameter int NB = N
) (
  input  logic [NB:0]   p,
  input  logic [NB-1:0] q,
  input  logic          q_m1,
  input  logic [NB-1:0] m,
  output logic [NB:0]   p_nxt,
  output logic [NB-1:0] q_nxt,
  output logic          q_m1_nxt
);

  logic [NB:0] m_ext;
  logic [NB:0] sum;

  // P is one bit wider than M, so subtracting the most negative M cannot overflow.
  assign m_ext = {m[NB-1], m};

  // Booth recoding: 01 adds M, 10 subtracts M, 00/11 leave P unchanged.
  always_comb begin
    sum = p;
    case ({q[0], q_m1})
      2'b01:   sum = p + m_ext;
      2'b10:   sum = p - m_ext;
      default: sum = p;
    endcase
  end

  // Arithmetic shift right by one: replicate the sign of P, and the old q-1 falls off the end.
  assign {p_nxt, q_nxt, q_m1_nxt} = {sum[NB], sum, q};

endmodule

// File: rtl/booth_mult.sv
// Sequential signed 32x32 radix-2 Booth multiplier (optional unsigned mode via BOOTH_MULT_MULTU_EN).
// Latency: N cycles from start to the done pulse (32, or 33 with BOOTH_MULT_MULTU_EN).
// Backpressure: start is ignored while busy; hi/lo hold until the next completed operation.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BOOTH_MULT_MULTU_EN
  input  logic             multu,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int NB = WIDTH + MULTU_EXT;

  state_t           state;
  logic [NB:0]      p;
  logic [NB-1:0]    q;
  logic [NB-1:0]    m;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;

  logic [NB-1:0]    a_ext;
  logic [NB-1:0]    b_ext;
  logic [NB:0]      p_nxt;
  logic [NB-1:0]    q_nxt;
  logic             q_m1_nxt;
  logic [CNT_W-1:0] cnt_dec;
  logic [2*NB:0]    prod_nxt;

`ifdef BOOTH_MULT_MULTU_EN
  // Unsigned operands are zero-extended into the extra bit; signed ones are sign-extended.
  assign a_ext = {a[WIDTH-1] & ~multu, a};
  assign b_ext = {b[WIDTH-1] & ~multu, b};
`else
  assign a_ext = a;
  assign b_ext = b;
`endif

  assign cnt_dec  = cnt - 1'b1;
  assign prod_nxt = {p_nxt, q_nxt};

  booth_step #(.NB(NB)) u_step (
    .p        (p),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .p_nxt    (p_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  // Control FSM, iteration datapath and registered outputs in a single process.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      p     <= '0;
      q     <= '0;
      m     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a_ext;
            q     <= b_ext;
            p     <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(NB);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p    <= p_nxt;
          q    <= q_nxt;
          q_m1 <= q_m1_nxt;
          cnt  <= cnt_dec;
          // The final step's result goes straight into hi/lo on the same edge.
          if (cnt_dec == '0) begin
            hi    <= prod_nxt[2*WIDTH-1:WIDTH];
            lo    <= prod_nxt[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a_ext;
            q     <= b_ext;
            p     <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(NB);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed vector table, random operands vs. arithmetic model, corner sequences.
// Latency: expects done exactly N edges after start (32, or 33 with BOOTH_MULT_MULTU_EN).
// Backpressure: covers start while busy (ignored), start in the done cycle, and asynchronous reset mid-operation.
module tb_booth_mult;

`ifdef BOOTH_MULT_MULTU_EN
  localparam int LAT   = 33;
  localparam bit HAS_U = 1'b1;
`else
  localparam int LAT   = 32;
  localparam bit HAS_U = 1'b0;
`endif
  localparam int TIMEOUT = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
`ifdef BOOTH_MULT_MULTU_EN
  logic        multu = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          u;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vt[$];

  booth_mult dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef BOOTH_MULT_MULTU_EN
    .multu (multu),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference: the exact mathematical product, truncated to 64 bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input bit u);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = u ? {32'b0, x} : {{32{x[31]}}, x};
    ey = u ? {32'b0, y} : {{32{y[31]}}, y};
    return ex * ey;
  endfunction

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input bit u,
                              input logic [63:0] e, input string n);
    vec_t v;
    v.a = x; v.b = y; v.u = u; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Presents one start pulse; returns at the negedge after the sampling edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit u);
    @(negedge clock);
    start = 1'b1;
    a = x;
    b = y;
`ifdef BOOTH_MULT_MULTU_EN
    multu = u;
`else
    if (u) $display("note: unsigned request ignored in signed-only build");
`endif
    @(negedge clock);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Waits for done; off counts edges since the start edge, bc counts cycles seen busy.
  task automatic wait_done(input int off0, output int off, output int bc);
    off = off0;
    bc  = 0;
    while (!done && off < TIMEOUT) begin
      if (busy) bc++;
      @(negedge clock);
      off++;
    end
  endtask

  task automatic run_check(input string name, input logic [31:0] x, input logic [31:0] y,
                           input bit u, input logic [63:0] exp);
    int off;
    int bc;
    launch(x, y, u);
    wait_done(0, off, bc);
    chk({name, " latency"}, 64'(off), 64'(LAT));
    chk({name, " busy_cycles"}, 64'(bc), 64'(LAT));
    chk({name, " busy_at_done"}, 64'(busy), 64'd0);
    chk({name, " product"}, {hi, lo}, exp);
    @(negedge clock);
    chk({name, " done_one_cycle"}, 64'(done), 64'd0);
    chk({name, " hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int off;
    int bc;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          ru;

    vt.push_back(mk(32'd3,        32'd5,        1'b0, 64'h0000_0000_0000_000F, "3x5"));
    vt.push_back(mk(32'hFFFF_FFF9, 32'd3,       1'b0, 64'hFFFF_FFFF_FFFF_FFEB, "m7x3"));
    vt.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001, "m1xm1"));
    vt.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "minxmin"));
    vt.push_back(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_0000_0001, "maxxmax"));
    vt.push_back(mk(32'h8000_0000, 32'd1,       1'b0, 64'hFFFF_FFFF_8000_0000, "minx1"));
    vt.push_back(mk(32'd0,        32'h1234_5678, 1'b0, 64'h0, "0xk"));
    if (HAS_U) begin
      vt.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, "u_m1xm1"));
      vt.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "u_minxmin"));
      vt.push_back(mk(32'hFFFF_FFFF, 32'd2,       1'b1, 64'h0000_0001_FFFF_FFFE, "u_m1x2"));
    end

    // Reset state
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle done", 64'(done), 64'd0);

    // Directed table
    for (int i = 0; i < vt.size(); i++)
      run_check(vt[i].name, vt[i].a, vt[i].b, vt[i].u, vt[i].exp);

    // Random operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 1) ra = 32'h8000_0000;
      if (i % 7 == 2) rb = 32'hFFFF_FFFF;
      ru = HAS_U ? 1'($urandom_range(0, 1)) : 1'b0;
      run_check($sformatf("rand%0d", i), ra, rb, ru, ref_prod(ra, rb, ru));
    end

    // start while busy is ignored
    launch(32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge clock);
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    wait_done(10, off, bc);
    chk("busy_start latency", 64'(off), 64'(LAT));
    chk("busy_start product", {hi, lo}, 64'd15);

    // start in the done cycle chains the next operation
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
`ifdef BOOTH_MULT_MULTU_EN
    multu = 1'b0;
`endif
    @(negedge clock);
    start = 1'b0;
    chk("chain busy", 64'(busy), 64'd1);
    chk("chain done_low", 64'(done), 64'd0);
    wait_done(0, off, bc);
    chk("chain latency", 64'(off), 64'(LAT));
    chk("chain product", {hi, lo}, 64'd81);
    @(negedge clock);

    // Asynchronous reset mid-operation
    launch(32'd7, 32'd6, 1'b0);
    repeat (12) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    off = 0;
    repeat (LAT + 4) begin
      @(negedge clock);
      if (done) off++;
    end
    chk("abort no_done", 64'(off), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    run_check("after_abort 2x2", 32'd2, 32'd2, 1'b0, 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
